uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 217, meaning clock cycles per serial bit; legal range 4..65535.
REQ-002 The module SHALL have port i_Clock, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-003 The module SHALL have port i_Rst_L, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port i_RX_Serial, input, 1 bit: asynchronous serial line, idle high.
REQ-005 The module SHALL have port o_RX_DV, output, 1 bit: one-cycle pulse marking a valid received byte.
REQ-006 The module SHALL have port o_RX_Byte, output, 8 bits: last received byte.

Function
REQ-007 The module SHALL receive 8N1 frames: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-008 i_RX_Serial SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value, adding 2 cycles of fixed latency.
REQ-009 The state machine SHALL have states IDLE, START, DATA, STOP, CLEANUP; encodings are free.
REQ-010 IDLE: clock counter and bit index SHALL be held at 0; when the synchronized line is 0, go to START.
REQ-011 START: count cycles; when the counter reaches (CLKS_PER_BIT-1)/2 (integer division), sample the line; if 0, clear the counter and go to DATA; if 1 (glitch), return to IDLE with no output.
REQ-012 DATA: after each further CLKS_PER_BIT cycles, sample the line into o_RX_Byte[bit index] and clear the counter; after bit index 7 is sampled, clear the index and go to STOP; otherwise increment the index.
REQ-013 o_RX_Byte bits SHALL be written in place as sampled; the value is only guaranteed while o_RX_DV is high and afterwards until the next frame's first data bit.
REQ-014 STOP: after CLKS_PER_BIT cycles, sample the line; if 1, drive o_RX_DV high for exactly one cycle; if 0 (framing error), do not assert o_RX_DV; in both cases go to CLEANUP.
REQ-015 CLEANUP: lasts exactly one cycle, drives o_RX_DV low, then goes to IDLE; a new start bit is accepted from IDLE onward.
REQ-016 o_RX_DV SHALL be high for exactly one cycle per valid frame, never two consecutive cycles.
REQ-017 A line held low continuously (break) SHALL produce at most one framing-error frame and no o_RX_DV until the line returns high and falls again.
REQ-018 Counter width SHALL be $clog2(CLKS_PER_BIT)+1 bits; no wrap-around within a bit period.

Reset
REQ-019 While i_Rst_L is 0, the state SHALL be IDLE, o_RX_DV 0, o_RX_Byte 8'h00, counter 0, bit index 0, and synchronizer flops 1 (idle line).
REQ-020 Reset asserted mid-frame SHALL abort the frame with no o_RX_DV; after release the receiver SHALL wait for a new falling edge.
REQ-021 Reset deassertion SHALL take effect on the next rising edge with no other side effects.

Verification (CLKS_PER_BIT=8)
REQ-022 Send 8'h41 with correct framing -> o_RX_DV pulses once for 1 cycle about 9.5 bit periods after the start edge (plus 2 sync cycles), with o_RX_Byte=8'h41.
REQ-023 Send 8'h0D then 8'hA5 back-to-back (stop bit immediately followed by start bit) -> two single-cycle pulses, bytes 8'h0D then 8'hA5.
REQ-024 Low glitch of 2 cycles on an idle line -> no o_RX_DV; a following valid 8'h72 is received correctly.
REQ-025 Frame 8'hFF with stop bit 0 -> no o_RX_DV; the next valid frame 8'h30 is received.
REQ-026 Assert i_Rst_L low during data bit 4 of a frame -> o_RX_DV stays 0 and o_RX_Byte=8'h00; after release, frame 8'h08 is received correctly.
REQ-027 Repeat REQ-022 with CLKS_PER_BIT=868 and 8'h67 -> same single pulse and byte, with timing scaled.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 2-flop input synchronizer and mid-bit sampling
module uart_rx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;

    state_t        state, state_n;
    logic          sync_q1, sync_q2;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    rx_byte, rx_byte_n;
    logic          dv, dv_n;
    logic          wait_high, wait_high_n;
    logic          line;

    assign line      = sync_q2;
    assign o_RX_DV   = dv;
    assign o_RX_Byte = rx_byte;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_q1   <= 1'b1;
            sync_q2   <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            rx_byte   <= 8'h00;
            dv        <= 1'b0;
            wait_high <= 1'b0;
        end else begin
            sync_q1   <= i_RX_Serial;
            sync_q2   <= sync_q1;
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            rx_byte   <= rx_byte_n;
            dv        <= dv_n;
            wait_high <= wait_high_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        rx_byte_n   = rx_byte;
        dv_n        = 1'b0;
        wait_high_n = wait_high;
        case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                // After a framing error the line must go high before a new start is accepted (break handling).
                if (line) begin
                    wait_high_n = 1'b0;
                end else if (!wait_high) begin
                    state_n = START;
                end
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    state_n = line ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_n          = '0;
                    rx_byte_n[idx] = line;
                    if (idx == 3'd7) begin
                        idx_n   = '0;
                        state_n = STOP;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = CLEANUP;
                    if (line) begin
                        dv_n = 1'b1;
                    end else begin
                        wait_high_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            CLEANUP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - table-driven bench for uart_rx at 8 and 868 clocks per bit
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line8 = 1'b1;
    logic       line_l = 1'b1;
    logic       dv8, dv_l;
    logic [7:0] byte8, byte_l;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.CLKS_PER_BIT(8)) dut8 (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(line8),
        .o_RX_DV(dv8), .o_RX_Byte(byte8)
    );

    uart_rx #(.CLKS_PER_BIT(868)) dut_l (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(line_l),
        .o_RX_DV(dv_l), .o_RX_Byte(byte_l)
    );

    logic [7:0] recv_q[$];
    int pulses8 = 0, pulses_l = 0, doubles = 0;
    int last_dv8 = 0, last_dv_l = 0;
    logic prev8 = 1'b0, prev_l = 1'b0;

    always @(negedge clk) begin
        if (dv8) begin
            recv_q.push_back(byte8);
            pulses8++;
            last_dv8 = cyc;
            if (prev8) doubles++;
        end
        if (dv_l) begin
            pulses_l++;
            last_dv_l = cyc;
            if (prev_l) doubles++;
        end
        prev8  = dv8;
        prev_l = dv_l;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_line(input bit big, input logic v);
        if (big) line_l = v;
        else     line8  = v;
    endtask

    // Drives a full frame starting at a falling clock edge; t0 is cyc at the start edge.
    task automatic send_frame(input bit big, input logic [7:0] d, input logic stop, output int t0);
        int c;
        c = big ? 868 : 8;
        set_line(big, 1'b0);
        t0 = cyc;
        repeat (c) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            set_line(big, d[b]);
            repeat (c) @(negedge clk);
        end
        set_line(big, stop);
        repeat (c) @(negedge clk);
        set_line(big, 1'b1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap_bits;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] exp_q[$];

    initial begin
        int t0;
        int p;

        vecs[0] = '{8'h41, 1'b1, 2};
        vecs[1] = '{8'h0D, 1'b1, 0};
        vecs[2] = '{8'hA5, 1'b1, 2};
        vecs[3] = '{8'hFF, 1'b0, 2};
        vecs[4] = '{8'h30, 1'b1, 2};
        vecs[5] = '{8'h00, 1'b1, 1};
        vecs[6] = '{8'h80, 1'b1, 1};
        vecs[7] = '{8'h5A, 1'b1, 2};

        repeat (3) @(negedge clk);
        chk("reset_dv8", dv8, 0);
        chk("reset_byte8", byte8, 8'h00);
        chk("reset_dv_l", dv_l, 0);
        chk("reset_byte_l", byte_l, 8'h00);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            send_frame(1'b0, vecs[i].data, vecs[i].stop, t0);
            if (vecs[i].stop) exp_q.push_back(vecs[i].data);
            repeat (vecs[i].gap_bits * 8) @(negedge clk);
            if (vecs[i].gap_bits > 0)
                chk($sformatf("pulse_count_v%0d", i), pulses8, exp_q.size());
            if (i == 0)
                chk("latency_41", last_dv8 - t0, 79);
        end

        // Two-cycle low glitch on an idle line must be rejected at the half-bit check.
        p = pulses8;
        line8 = 1'b0;
        repeat (2) @(negedge clk);
        line8 = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_no_dv", pulses8, p);
        send_frame(1'b0, 8'h72, 1'b1, t0);
        exp_q.push_back(8'h72);
        repeat (16) @(negedge clk);
        chk("after_glitch", pulses8, exp_q.size());

        // Break: line held low for many frame times.
        p = pulses8;
        line8 = 1'b0;
        repeat (240) @(negedge clk);
        line8 = 1'b1;
        repeat (16) @(negedge clk);
        chk("break_no_dv", pulses8, p);
        send_frame(1'b0, 8'h3C, 1'b1, t0);
        exp_q.push_back(8'h3C);
        repeat (16) @(negedge clk);
        chk("after_break", pulses8, exp_q.size());

        // Reset in the middle of data bit 4 of an 8'hFF frame.
        p = pulses8;
        line8 = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            line8 = 1'b1;
            if (b == 4) begin
                repeat (4) @(negedge clk);
                rst_n = 1'b0;
                #1;
                chk("midframe_rst_dv", dv8, 0);
                chk("midframe_rst_byte", byte8, 8'h00);
                repeat (4) @(negedge clk);
            end else begin
                repeat (8) @(negedge clk);
            end
        end
        line8 = 1'b1;
        repeat (16) @(negedge clk);
        chk("rst_frame_no_dv", pulses8, p);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(1'b0, 8'h08, 1'b1, t0);
        exp_q.push_back(8'h08);
        repeat (16) @(negedge clk);
        chk("after_reset_frame", pulses8, exp_q.size());

        chk("recv_count", recv_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < recv_q.size(); k++)
            chk($sformatf("recv_byte_%0d", k), recv_q[k], exp_q[k]);

        // Slow-rate instance.
        send_frame(1'b1, 8'h67, 1'b1, t0);
        repeat (2 * 868) @(negedge clk);
        chk("big_pulses", pulses_l, 1);
        chk("big_byte", byte_l, 8'h67);
        chk("big_latency", last_dv_l - t0, 4 + 433 + 9 * 868);

        chk("no_double_pulse", doubles, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
